// File: rtl/vga_text_if.sv
// Pixel-side bundle of the VGA text display: colour switches in, sync and colour out.
interface vga_text_if;
   logic [1:0] BP_R;
   logic [1:0] BP_G;
   logic [1:0] BP_B;
   logic       hsync;
   logic       vsync;
   logic [2:0] text_rgb;

   modport master (input BP_R, BP_G, BP_B, output hsync, vsync, text_rgb);
   modport slave  (output BP_R, BP_G, BP_B, input hsync, vsync, text_rgb);
endinterface

// File: rtl/vga_text_top.sv
// 640x480@60 VGA timing with a 4-digit hex frame counter drawn in the top-left cells.
module vga_text_top #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       rst,
   vga_text_if.master vga
);
   localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] HS_START  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_START  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [15:0] frame_cnt;

   logic        hs_low;
   logic        vs_low;
   logic        visible;
   logic        in_text;
   logic [3:0]  digit;
   logic [47:0] glyph;
   logic [7:0]  font_row;
   logic        pen;
   logic [2:0]  pix;

   assign hs_low  = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_low  = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign visible = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
   assign in_text = (v_cnt[8:3] == 6'd0) && (h_cnt[9:3] < 7'd4);

   always_comb begin
      digit = frame_cnt[15:12];
      case (h_cnt[4:3])
         2'd0:    digit = frame_cnt[15:12];
         2'd1:    digit = frame_cnt[11:8];
         2'd2:    digit = frame_cnt[7:4];
         default: digit = frame_cnt[3:0];
      endcase
   end

   // Only glyph rows 1..6 are stored; rows 0 and 7 are the blank spacing border.
   always_comb begin
      glyph = '0;
      case (digit)
         4'h0: glyph = 48'h3C_42_42_42_42_3C;
         4'h1: glyph = 48'h08_18_08_08_08_1C;
         4'h2: glyph = 48'h3C_42_04_18_20_7E;
         4'h3: glyph = 48'h7C_02_1C_02_02_7C;
         4'h4: glyph = 48'h0C_14_24_7E_04_04;
         4'h5: glyph = 48'h7E_40_7C_02_02_7C;
         4'h6: glyph = 48'h3C_40_7C_42_42_3C;
         4'h7: glyph = 48'h7E_02_04_08_10_10;
         4'h8: glyph = 48'h3C_42_3C_42_42_3C;
         4'h9: glyph = 48'h3C_42_42_3E_02_3C;
         4'hA: glyph = 48'h18_24_42_7E_42_42;
         4'hB: glyph = 48'h7C_42_7C_42_42_7C;
         4'hC: glyph = 48'h3C_42_40_40_42_3C;
         4'hD: glyph = 48'h78_44_42_42_44_78;
         4'hE: glyph = 48'h7E_40_7C_40_40_7E;
         default: glyph = 48'h7E_40_7C_40_40_40;
      endcase
      font_row = '0;
      case (v_cnt[2:0])
         3'd1:    font_row = glyph[47:40];
         3'd2:    font_row = glyph[39:32];
         3'd3:    font_row = glyph[31:24];
         3'd4:    font_row = glyph[23:16];
         3'd5:    font_row = glyph[15:8];
         3'd6:    font_row = glyph[7:0];
         default: font_row = '0;
      endcase
   end

   assign pen = font_row[3'd7 - h_cnt[2:0]];

   always_comb begin
      pix = 3'b000;
      if (visible) begin
         if (in_text && pen) pix = {vga.BP_R[0], vga.BP_G[0], vga.BP_B[0]};
         else                pix = {vga.BP_R[1], vga.BP_G[1], vga.BP_B[1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt        <= '0;
         v_cnt        <= '0;
         frame_cnt    <= '0;
         vga.hsync    <= 1'b1;
         vga.vsync    <= 1'b1;
         vga.text_rgb <= 3'b000;
      end else begin
         vga.hsync    <= ~hs_low;
         vga.vsync    <= ~vs_low;
         vga.text_rgb <= pix;
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt     <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end
endmodule

// File: tb/tb_vga_text_top.sv
// Directed bench for vga_text_top; vertical timing shortened to 24 lines so several frames fit.
module tb_vga_text_top;
   localparam int LINE  = 800;
   localparam int FRAME = 24 * LINE;

   logic clk;
   logic rst;
   int   edges;
   int   vectors;
   int   miscompares;
   int   n;
   int   f1;

   vga_text_if vif ();

   vga_text_top #(
      .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vga(vif)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pix(input int x, input int y, input int f);
      return f * FRAME + y * LINE + x;
   endfunction

   // Outputs reflect pixel p once p+1 edges have passed since reset release.
   task automatic goto(input int p);
      while (edges < p + 1) tick();
   endtask

   task automatic wait_level(input bit use_v, input logic lvl, input int limit, output int cnt);
      cnt = 0;
      while (((use_v ? vif.vsync : vif.hsync) !== lvl) && cnt < limit) begin
         tick();
         cnt++;
      end
   endtask

   task automatic set_bp(input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
      vif.BP_R = r;
      vif.BP_G = g;
      vif.BP_B = b;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      edges = 0;
      rst = 1'b1;
      set_bp(2'b10, 2'b01, 2'b00);
      tick();
      tick();
      check("rst_hsync", 32'(vif.hsync), 1);
      check("rst_vsync", 32'(vif.vsync), 1);
      check("rst_rgb", 32'(vif.text_rgb), 0);

      rst = 1'b0;
      edges = 0;
      wait_level(1'b0, 1'b0, 2000, n);
      check("first_hfall", edges, 657);
      f1 = edges;
      wait_level(1'b0, 1'b1, 2000, n);
      check("hlow_width", n, 96);
      wait_level(1'b0, 1'b0, 2000, n);
      check("h_period", edges - f1, 800);
      wait_level(1'b0, 1'b1, 2000, n);
      check("hlow_width2", n, 96);

      goto(pix(0, 3, 0));   check("px0_3_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(1, 3, 0));   check("px1_3_fg", 32'(vif.text_rgb), 3'b010);
      goto(pix(2, 3, 0));   check("px2_3_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(6, 3, 0));   check("px6_3_fg", 32'(vif.text_rgb), 3'b010);
      goto(pix(9, 3, 0));   check("px9_3_fg", 32'(vif.text_rgb), 3'b010);
      goto(pix(25, 3, 0));  check("px25_3_fg", 32'(vif.text_rgb), 3'b010);
      goto(pix(33, 3, 0));  check("px33_3_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(40, 3, 0));  check("px40_3_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(640, 3, 0)); check("px640_3_blank", 32'(vif.text_rgb), 3'b000);

      goto(pix(0, 5, 0));   check("px0_5_bg", 32'(vif.text_rgb), 3'b100);
      set_bp(2'b11, 2'b11, 2'b11);
      tick();
      check("px1_5_white", 32'(vif.text_rgb), 3'b111);
      goto(pix(100, 5, 0)); check("px100_5_white", 32'(vif.text_rgb), 3'b111);
      goto(pix(639, 5, 0)); check("px639_5_white", 32'(vif.text_rgb), 3'b111);
      goto(pix(640, 5, 0)); check("px640_5_blank", 32'(vif.text_rgb), 3'b000);
      goto(pix(799, 5, 0)); check("px799_5_blank", 32'(vif.text_rgb), 3'b000);
      goto(pix(100, 16, 0)); check("px100_16_vblank", 32'(vif.text_rgb), 3'b000);
      set_bp(2'b10, 2'b01, 2'b00);

      wait_level(1'b1, 1'b0, 30000, n);
      check("first_vfall", edges, 18 * LINE + 1);
      f1 = edges;
      wait_level(1'b1, 1'b1, 5000, n);
      check("vlow_width", n, 1600);

      goto(pix(0, 0, 1));   check("f1_px0_0_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(19, 2, 1));  check("f1_px19_2_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(27, 2, 1));  check("f1_px27_2_fg", 32'(vif.text_rgb), 3'b010);

      wait_level(1'b1, 1'b0, 30000, n);
      check("v_period", edges - f1, FRAME);

      goto(pix(1, 3, 2));   check("f2_px1_3_fg", 32'(vif.text_rgb), 3'b010);
      goto(pix(5, 3, 2));   check("f2_px5_3_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(25, 3, 2));  check("f2_px25_3_bg", 32'(vif.text_rgb), 3'b100);
      goto(pix(29, 3, 2));  check("f2_px29_3_fg", 32'(vif.text_rgb), 3'b010);

      goto(pix(700, 3, 2)); check("f2_hsync_low", 32'(vif.hsync), 0);
      rst = 1'b1;
      tick();
      check("mid_rst_hsync", 32'(vif.hsync), 1);
      check("mid_rst_vsync", 32'(vif.vsync), 1);
      check("mid_rst_rgb", 32'(vif.text_rgb), 0);
      rst = 1'b0;
      edges = 0;
      wait_level(1'b0, 1'b0, 2000, n);
      check("restart_hfall", edges, 657);
      goto(pix(25, 3, 0));  check("restart_px25_3_fg", 32'(vif.text_rgb), 3'b010);
      goto(pix(29, 3, 0));  check("restart_px29_3_bg", 32'(vif.text_rgb), 3'b100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vga_text_top.md
Name: vga_text_top

Overview:
- Top-level 640x480@60 Hz VGA text display driven directly by the 25 MHz board clock (40 ns period).
- Generates hsync and vsync, and a 3-bit colour output.
- Shows a 4-digit hex frame counter in the top-left character cell row on a user-selected background. Foreground and background colours come from the switch inputs BP_R, BP_G and BP_B.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (line total 800)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (frame total 525)

Ports:
- clk  input  1  25 MHz pixel clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- BP_R  input  2  [1]=background red, [0]=foreground (pen) red
- BP_G  input  2  [1]=background green, [0]=foreground green
- BP_B  input  2  [1]=background blue, [0]=foreground blue
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- text_rgb  output  3  {R,G,B} pixel colour, 1 bit per channel

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - h_cnt=0, v_cnt=0, frame_cnt (16-bit)=0
  - hsync=1, vsync=1, text_rgb=3'b000
- h_cnt counts 0..799 and wraps to 0. v_cnt increments when h_cnt=799 and wraps 524->0.
- frame_cnt increments by 1 (mod 2^16) when h_cnt=799 and v_cnt=524.
- Sync windows (combinational from counters):
  - hsync low iff 656<=h_cnt<=751
  - vsync low iff 490<=v_cnt<=491
- Visible iff h_cnt<640 and v_cnt<480.
- Character grid:
  - 8x8-pixel cells. col=h_cnt[9:3], row=v_cnt[8:3], glyph x=h_cnt[2:0], glyph y=v_cnt[2:0].
  - Text region: row 0, cols 0..3. Col 0 shows frame_cnt[15:12] down to col 3 showing frame_cnt[3:0], as hex digits 0-9, A-F.
- Font ROM (combinational, 16 glyphs x 8 rows x 8 bits):
  - bit 7 is the leftmost pixel.
  - Every glyph has row 0, row 7, bit 7 and bit 0 all zero, giving a 1-pixel spacing border.
  - Glyph shapes inside the 6x6 interior are implementer's choice but must be distinct per digit.
  - Fixed anchor: glyph '0' row 3 = 8'b0100_0010.
- Pixel selection:
  - In the text region with glyph bit=1: {BP_R[0],BP_G[0],BP_B[0]}.
  - Elsewhere visible: {BP_R[1],BP_G[1],BP_B[1]}.
  - Outside visible area: 3'b000.
- hsync, vsync and text_rgb are all registered, so outputs reflect the counter values of the previous clock (1-cycle latency, all three aligned).
- BP_* are sampled every pixel with no synchronisation or latching, so a change affects the next registered pixel.
- rst asserted mid-frame returns everything to reset values on the next edge. Counting restarts from (0,0) after rst deasserts.

Test Plan:
- Reset: rst=1 for 2 clocks -> hsync=1, vsync=1, text_rgb=000. Release rst -> first hsync falling edge 657 clocks after the first non-reset edge.
- Line timing: measure hsync -> low exactly 96 clocks, period exactly 800 clocks, repeating.
- Frame timing: run one full frame (420000 clocks) -> vsync low exactly 1600 clocks, starting with the line-490 start (+1 clock lag), period 420000 clocks.
- Blanking: BP_R=BP_G=BP_B=2'b11 -> text_rgb=111 in every visible pixel, and 000 for h_cnt>=640 or v_cnt>=480.
- Text colours: BP_R=2'b10, BP_G=2'b01, BP_B=2'b00, frame_cnt=0.
  - Pixel (x=1,y=3) -> glyph '0' bit 6=1 -> fg 010.
  - Pixel (x=0,y=0) -> bg 100.
  - Pixel (x=40,y=3), outside the text region -> bg 100.
- Counter/mid-reset: after 2 full frames, cell col 3 shows glyph '2' while cells 0..2 show '0'. Assert rst mid-line -> next edge outputs 1/1/000 and frame_cnt=0.
